// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Types and default constants shared by the unified-memory arbiter.
//   rsp_own_t        : which requester owns the read currently in flight
//   MEM_ARB_ADDR_W   : default byte-address width
//   MEM_ARB_DATA_W   : default data width
//   MEM_ARB_MAX_RUN  : default number of data grants allowed while fetch waits
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int MEM_ARB_ADDR_W  = 32;
  localparam int MEM_ARB_DATA_W  = 32;
  localparam int MEM_ARB_MAX_RUN = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } rsp_own_t;

endpackage

// File: rtl/mem_arb_run_cnt.sv
// -----------------------------------------------------------------------------
// mem_arb_run_cnt
// Counts consecutive data grants taken while fetch is waiting, and raises
// force_if once the run reaches MAX_RUN so fetch gets the next slot.
// Only instantiated when MEM_ARB_FAIRNESS_EN is defined.
//   clk       in  clock
//   rst       in  synchronous active-low reset
//   if_valid  in  fetch request pending
//   if_grant  in  fetch granted this cycle
//   d_grant   in  data granted this cycle
//   force_if  out fetch must win arbitration this cycle
// -----------------------------------------------------------------------------
module mem_arb_run_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX_RUN = MEM_ARB_MAX_RUN
) (
  input  logic clk,
  input  logic rst,
  input  logic if_valid,
  input  logic if_grant,
  input  logic d_grant,
  output logic force_if
);

  localparam int CNT_W = $clog2(MAX_RUN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RUN);

  logic [CNT_W-1:0] run_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_cnt <= '0;
    end else if (!if_valid || if_grant) begin
      run_cnt <= '0;
    end else if (d_grant && run_cnt != CNT_MAX) begin
      run_cnt <= run_cnt + CNT_W'(1);
    end
  end

  assign force_if = if_valid && (run_cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port synchronous RAM between instruction fetch and
// load/store. Grants at most one access per cycle (data over fetch), records
// which requester owns the in-flight read and steers the 1-cycle read data
// back to it.
// Build option: define MEM_ARB_FAIRNESS_EN to let fetch win one slot after
// MAX_DATA_RUN consecutive data grants; otherwise data priority is strict.
//   clk, rst                       clock, synchronous active-low reset
//   if_req_valid/addr/ready        fetch request channel
//   if_rsp_valid/data              fetch read response
//   d_req_valid/we/addr/wdata/wstrb/ready  load/store request channel
//   d_rsp_valid/data               load response (never for stores)
//   mem_en/we/addr/wdata/wstrb     memory request, word-aligned address
//   mem_rdata                      memory read data, one cycle after read
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = MEM_ARB_ADDR_W,
  parameter int DATA_W       = MEM_ARB_DATA_W,
  parameter int MAX_DATA_RUN = MEM_ARB_MAX_RUN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                d_req_valid,
  input  logic                d_req_we,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  output logic                d_req_ready,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  if (MAX_DATA_RUN < 1) begin : g_bad_run
    $error("mem_arbiter: MAX_DATA_RUN must be at least 1");
  end

  logic     force_if;
  logic     d_win;
  logic [ADDR_W-1:0] sel_addr;
  rsp_own_t rsp_own;

`ifdef MEM_ARB_FAIRNESS_EN
  mem_arb_run_cnt #(
    .MAX_RUN (MAX_DATA_RUN)
  ) u_run_cnt (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_req_valid),
    .if_grant (if_req_ready),
    .d_grant  (d_req_ready),
    .force_if (force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  // Data wins unless the fairness counter has handed this slot to fetch.
  // Both readies are held low for as long as reset is asserted.
  assign d_win        = d_req_valid && !force_if;
  assign d_req_ready  = rst && d_win;
  assign if_req_ready = rst && if_req_valid && !d_win;

  assign mem_en    = if_req_ready || d_req_ready;
  assign mem_we    = d_req_ready && d_req_we;
  assign mem_wstrb = mem_we ? d_req_wstrb : '0;
  assign mem_wdata = d_req_wdata;

  // The low two address bits are masked rather than sliced so the whole
  // request address stays in use; misalignment is the requester's problem.
  assign sel_addr = d_req_ready ? d_req_addr : if_req_addr;
  assign mem_addr = sel_addr & ~ADDR_W'(3);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_own <= OWN_NONE;
    end else if (d_req_ready && !d_req_we) begin
      rsp_own <= OWN_D;
    end else if (if_req_ready) begin
      rsp_own <= OWN_IF;
    end else begin
      rsp_own <= OWN_NONE;
    end
  end

  assign if_rsp_valid = (rsp_own == OWN_IF);
  assign d_rsp_valid  = (rsp_own == OWN_D);
  assign if_rsp_data  = mem_rdata;
  assign d_rsp_data   = mem_rdata;

endmodule
